// File: rtl/hazard_control_unit.sv
// Hazard sequencer: load-use stall, data-memory freeze, branch squash and fetch shadow.
// In: ID sources, EX load/rd/branch, MEM req/ready. Out: per-register stall/flush/bubble, state, counters.
module hazard_control_unit #(
  parameter int unsigned FETCH_LATENCY = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_ID_rs1,
  input  logic [4:0]       i_ID_rs2,
  input  logic             i_ID_UsesRs1,
  input  logic             i_ID_UsesRs2,
  input  logic             i_EX_MemRead,
  input  logic [4:0]       i_EX_rd,
  input  logic             i_EX_BranchTaken,
  input  logic             i_MEM_Req,
  input  logic             i_MEM_Ready,
  output logic             o_PC_Stall,
  output logic             o_IFID_Stall,
  output logic             o_IFID_Flush,
  output logic             o_IDEX_Stall,
  output logic             o_IDEX_Bubble,
  output logic             o_EXMEM_Stall,
  output logic             o_MEMWB_Bubble,
  output logic [1:0]       o_State,
  output logic [CNT_W-1:0] o_StallCycles,
  output logic [CNT_W-1:0] o_FlushCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0] SHADOW_INIT = 2'(FETCH_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  state_t     state_nxt;
  logic [1:0] shadow_cnt;
  logic [1:0] shadow_nxt;

  logic mem_stall;
  logic load_use;
  logic redirect;
  logic shadow;
  logic rs1_hit;
  logic rs2_hit;

  assign mem_stall = i_MEM_Req & ~i_MEM_Ready;
  assign rs1_hit   = i_ID_UsesRs1 & (i_EX_rd == i_ID_rs1);
  assign rs2_hit   = i_ID_UsesRs2 & (i_EX_rd == i_ID_rs2);
  assign load_use  = i_EX_MemRead & (i_EX_rd != 5'd0)
                   & (rs1_hit | rs2_hit);
  assign redirect  = i_EX_BranchTaken;
  assign shadow    = (shadow_cnt != 2'd0);

  // One-hot case selects encoding the priority order;
  // reset overrides everything asynchronously.
  logic sel_rst;
  logic sel_mem;
  logic sel_red;
  logic sel_lu;
  logic sel_shd;

  assign sel_rst = ~i_rst_n;
  assign sel_mem = i_rst_n & mem_stall;
  assign sel_red = i_rst_n & ~mem_stall & redirect;
  assign sel_lu  = i_rst_n & ~mem_stall & ~redirect & load_use;
  assign sel_shd = i_rst_n & ~mem_stall & ~redirect
                 & ~load_use & shadow;

  always_comb begin
    o_PC_Stall     = 1'b0;
    o_IFID_Stall   = 1'b0;
    o_IFID_Flush   = 1'b0;
    o_IDEX_Stall   = 1'b0;
    o_IDEX_Bubble  = 1'b0;
    o_EXMEM_Stall  = 1'b0;
    o_MEMWB_Bubble = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        o_IFID_Flush   = 1'b1;
        o_IDEX_Bubble  = 1'b1;
        o_MEMWB_Bubble = 1'b1;
      end
      sel_mem: begin
        o_PC_Stall     = 1'b1;
        o_IFID_Stall   = 1'b1;
        o_IDEX_Stall   = 1'b1;
        o_EXMEM_Stall  = 1'b1;
        o_MEMWB_Bubble = 1'b1;
      end
      sel_red: begin
        o_IFID_Flush  = 1'b1;
        o_IDEX_Bubble = 1'b1;
      end
      sel_lu: begin
        o_PC_Stall    = 1'b1;
        o_IFID_Stall  = 1'b1;
        o_IDEX_Bubble = 1'b1;
      end
      sel_shd: begin
        o_IFID_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Fetch latency keeps elapsing under a load-use hold,
  // but the whole pipe (fetch included) freezes on mem_stall.
  always_comb begin
    shadow_nxt = shadow_cnt;
    if (mem_stall)
      shadow_nxt = shadow_cnt;
    else if (redirect)
      shadow_nxt = SHADOW_INIT;
    else if (shadow)
      shadow_nxt = shadow_cnt - 2'd1;
  end

  always_comb begin
    state_nxt = RUN;
    if (mem_stall)
      state_nxt = MEM_WAIT;
    else if (redirect | shadow)
      state_nxt = REDIRECT;
    else if (load_use)
      state_nxt = LOAD_USE;
  end

  // A load-use masked by a redirect never stalls, so it is not counted.
  logic stall_evt;
  assign stall_evt = mem_stall | (load_use & ~redirect);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      shadow_cnt    <= SHADOW_INIT;
      o_StallCycles <= '0;
      o_FlushCycles <= '0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_nxt;
      if (stall_evt && o_StallCycles != CNT_MAX)
        o_StallCycles <= o_StallCycles + 1'b1;
      if (o_IFID_Flush && o_FlushCycles != CNT_MAX)
        o_FlushCycles <= o_FlushCycles + 1'b1;
    end
  end

  assign o_State = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit.
// Default instance plus a CNT_W=4 instance for saturation.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use1;
  logic       id_use2;
  logic       ex_memrd;
  logic [4:0] ex_rd;
  logic       ex_br;
  logic       mem_req;
  logic       mem_rdy;

  logic        pc_s, ifid_s, ifid_f, idex_s, idex_b;
  logic        exmem_s, memwb_b;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_s4, ifid_s4, ifid_f4, idex_s4, idex_b4;
  logic        exmem_s4, memwb_b4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  logic [6:0] ctl;
  assign ctl = {pc_s, ifid_s, ifid_f, idex_s,
                idex_b, exmem_s, memwb_b};

  localparam logic [6:0] C_RST = 7'b0010101;
  localparam logic [6:0] C_MEM = 7'b1101011;
  localparam logic [6:0] C_RED = 7'b0010100;
  localparam logic [6:0] C_LU  = 7'b1100100;
  localparam logic [6:0] C_SHD = 7'b0010000;
  localparam logic [6:0] C_RUN = 7'b0000000;

  int n_vec = 0;
  int n_err = 0;

  hazard_control_unit dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_UsesRs1(id_use1), .i_ID_UsesRs2(id_use2),
    .i_EX_MemRead(ex_memrd), .i_EX_rd(ex_rd),
    .i_EX_BranchTaken(ex_br),
    .i_MEM_Req(mem_req), .i_MEM_Ready(mem_rdy),
    .o_PC_Stall(pc_s), .o_IFID_Stall(ifid_s),
    .o_IFID_Flush(ifid_f), .o_IDEX_Stall(idex_s),
    .o_IDEX_Bubble(idex_b), .o_EXMEM_Stall(exmem_s),
    .o_MEMWB_Bubble(memwb_b), .o_State(state),
    .o_StallCycles(stall_cnt), .o_FlushCycles(flush_cnt)
  );

  hazard_control_unit #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_UsesRs1(id_use1), .i_ID_UsesRs2(id_use2),
    .i_EX_MemRead(ex_memrd), .i_EX_rd(ex_rd),
    .i_EX_BranchTaken(ex_br),
    .i_MEM_Req(mem_req), .i_MEM_Ready(mem_rdy),
    .o_PC_Stall(pc_s4), .o_IFID_Stall(ifid_s4),
    .o_IFID_Flush(ifid_f4), .o_IDEX_Stall(idex_s4),
    .o_IDEX_Bubble(idex_b4), .o_EXMEM_Stall(exmem_s4),
    .o_MEMWB_Bubble(memwb_b4), .o_State(state4),
    .o_StallCycles(stall_cnt4), .o_FlushCycles(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rs1   = 5'd0;
    id_rs2   = 5'd0;
    id_use1  = 1'b0;
    id_use2  = 1'b0;
    ex_memrd = 1'b0;
    ex_rd    = 5'd0;
    ex_br    = 1'b0;
    mem_req  = 1'b0;
    mem_rdy  = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] r1,
                        input logic       u1,
                        input logic [4:0] r2,
                        input logic       u2);
    ex_memrd = 1'b1;
    ex_rd    = rd;
    id_rs1   = r1;
    id_use1  = u1;
    id_rs2   = r2;
    id_use2  = u2;
  endtask

  // Next cycle: inputs change 1 after the edge,
  // outputs are sampled 2 after the edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst_n = 1'b0;
    set_idle();
    next_cyc();
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (ctl !== C_RST) begin
      n_err++;
      $display("FAIL rst_ctl got %b exp %b", ctl, C_RST);
    end
    n_vec++;
    if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++;
      $display("FAIL rst_regs got st=%0d sc=%0d fc=%0d exp 0/0/0",
               state, stall_cnt, flush_cnt);
    end
    next_cyc();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_SHD) begin
      n_err++;
      $display("FAIL rel_shadow got %b exp %b", ctl, C_SHD);
    end
    next_cyc();
    #1;
    n_vec++;
    if (ctl !== C_RUN || state !== 2'd3 || flush_cnt !== 1) begin
      n_err++;
      $display("FAIL rel_c1 got ctl=%b st=%0d fc=%0d exp 0000000/3/1",
               ctl, state, flush_cnt);
    end
    next_cyc();
    #1;
    n_vec++;
    if (state !== 2'd0 || flush_cnt !== 1) begin
      n_err++;
      $display("FAIL rel_c2 got st=%0d fc=%0d exp 0/1",
               state, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    next_cyc();
    set_lu(5'd5, 5'd1, 1'b0, 5'd5, 1'b1);
    #1;
    n_vec++;
    if (ctl !== C_LU) begin
      n_err++;
      $display("FAIL lu_rs2 got %b exp %b", ctl, C_LU);
    end
    next_cyc();
    set_idle();
    #1;
    n_vec++;
    if (ctl !== C_RUN || state !== 2'd1 || stall_cnt !== 1) begin
      n_err++;
      $display("FAIL lu_after got ctl=%b st=%0d sc=%0d exp 0000000/1/1",
               ctl, state, stall_cnt);
    end
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    n_vec++;
    if (ctl !== C_RUN) begin
      n_err++;
      $display("FAIL lu_rd0 got %b exp %b", ctl, C_RUN);
    end
    next_cyc();
    set_lu(5'd7, 5'd7, 1'b1, 5'd2, 1'b0);
    #1;
    n_vec++;
    if (ctl !== C_LU || state !== 2'd0 || stall_cnt !== 1) begin
      n_err++;
      $display("FAIL lu_rs1 got ctl=%b st=%0d sc=%0d exp 1100100/0/1",
               ctl, state, stall_cnt);
    end
    next_cyc();
    set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    #1;
    n_vec++;
    if (ctl !== C_RUN || stall_cnt !== 2) begin
      n_err++;
      $display("FAIL lu_nouse got ctl=%b sc=%0d exp 0000000/2",
               ctl, stall_cnt);
    end
    next_cyc();
    set_idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      mem_req = 1'b1;
      mem_rdy = 1'b0;
      ex_br   = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_MEM) begin
        n_err++;
        $display("FAIL mw_freeze%0d got %b exp %b", i, ctl, C_MEM);
      end
    end
    next_cyc();
    mem_rdy = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_RED || state !== 2'd2 || stall_cnt !== 3) begin
      n_err++;
      $display("FAIL mw_redir got ctl=%b st=%0d sc=%0d exp 0010100/2/3",
               ctl, state, stall_cnt);
    end
    next_cyc();
    set_idle();
    #1;
    n_vec++;
    if (ctl !== C_SHD || state !== 2'd3) begin
      n_err++;
      $display("FAIL mw_shadow got ctl=%b st=%0d exp 0010000/3",
               ctl, state);
    end
    next_cyc();
    #1;
    n_vec++;
    if (ctl !== C_RUN || flush_cnt !== 3 || stall_cnt !== 3) begin
      n_err++;
      $display("FAIL mw_done got ctl=%b fc=%0d sc=%0d exp 0000000/3/3",
               ctl, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_branch_vs_lu();
    next_cyc();
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    ex_br = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_RED) begin
      n_err++;
      $display("FAIL br_lu got %b exp %b", ctl, C_RED);
    end
    next_cyc();
    set_idle();
    #1;
    n_vec++;
    if (ctl !== C_SHD || stall_cnt !== 3 || state !== 2'd3) begin
      n_err++;
      $display("FAIL br_lu_next got ctl=%b sc=%0d st=%0d exp 0010000/3/3",
               ctl, stall_cnt, state);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      next_cyc();
      mem_req = 1'b1;
      mem_rdy = 1'b0;
      #1;
      if (i == 15) begin
        n_vec++;
        if (stall_cnt4 !== 4'd15) begin
          n_err++;
          $display("FAIL sat_at15 got %0d exp 15", stall_cnt4);
        end
      end
    end
    next_cyc();
    set_idle();
    #1;
    n_vec++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 20) begin
      n_err++;
      $display("FAIL sat_hold got c4=%0d c32=%0d exp 15/20",
               stall_cnt4, stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    next_cyc();
    mem_req = 1'b1;
    mem_rdy = 1'b0;
    next_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_RST || state !== 2'd0
        || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++;
      $display("FAIL arst got ctl=%b st=%0d sc=%0d fc=%0d exp 0010101/0/0/0",
               ctl, state, stall_cnt, flush_cnt);
    end
    next_cyc();
    set_idle();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_SHD) begin
      n_err++;
      $display("FAIL arst_rel got %b exp %b", ctl, C_SHD);
    end
    next_cyc();
    #1;
    n_vec++;
    if (ctl !== C_RUN || flush_cnt !== 1) begin
      n_err++;
      $display("FAIL arst_run got ctl=%b fc=%0d exp 0000000/1",
               ctl, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_vs_lu();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
